// File: rtl/ff_sync_filt.sv
// ff_sync_filt: STAGES-deep, WIDTH-bit synchroniser into dest_clk, optional whole-word stability filter, per-bit edge strobes.
// Latency: STAGES edges with FILTER=0, STAGES+FILTER edges otherwise; rise/fall/changed coincide with the first cycle of a new q.
// Backpressure: none; d is sampled on every edge and the outputs are always valid.
// Ports:
//   dest_clk  destination clock, all state on its rising edge
//   rst_n     asynchronous active-low reset (loads RESET_VAL, clears strobes)
//   d         asynchronous input word
//   q         synchronised (and optionally filtered) level
//   rise/fall per-bit one-cycle strobes for q[i] 0->1 / 1->0
//   changed   OR of all rise|fall bits
module ff_sync_filt #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       STAGES    = 2,
  parameter int unsigned       FILTER    = 0,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             dest_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  if (STAGES < 2) begin : g_bad_stages
    $error("ff_sync_filt: STAGES must be at least 2");
  end
  if (FILTER > 65535) begin : g_bad_filter
    $error("ff_sync_filt: FILTER must be within 0..65535");
  end

  // Synchroniser chain: plain flop-to-flop, nothing in between.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] q_lvl;
  logic [WIDTH-1:0] q_hist_q;

  always_ff @(posedge dest_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[STAGES-1];

  if (FILTER == 0) begin : g_nofilt
    // Unfiltered: the last synchroniser stage is the output level.
    assign q_lvl = s;
  end else if (FILTER == 1) begin : g_filt1
    // One consecutive sample is enough, so the filter collapses to a
    // single register that follows s one edge later.
    logic [WIDTH-1:0] fq_q;
    always_ff @(posedge dest_clk or negedge rst_n) begin
      if (!rst_n) begin
        fq_q <= RESET_VAL;
      end else begin
        fq_q <= s;
      end
    end
    assign q_lvl = fq_q;
  end else begin : g_filt
    localparam int unsigned  CW   = $clog2(FILTER + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER - 1);

    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] fq_q, fq_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // c holds the word currently being qualified; cnt counts how many
    // consecutive edges s has matched it. Any bit change restarts the
    // whole word, and cnt is cleared on acceptance or when c already
    // equals q, so it never wraps.
    always_comb begin
      c_d   = c_q;
      cnt_d = cnt_q;
      fq_d  = fq_q;
      if (s != c_q) begin
        c_d   = s;
        cnt_d = CW'(1);
      end else if (c_q == fq_q) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        fq_d  = c_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge dest_clk or negedge rst_n) begin
      if (!rst_n) begin
        c_q   <= RESET_VAL;
        fq_q  <= RESET_VAL;
        cnt_q <= '0;
      end else begin
        c_q   <= c_d;
        fq_q  <= fq_d;
        cnt_q <= cnt_d;
      end
    end

    assign q_lvl = fq_q;
  end

  // History of q for edge detection; reset to RESET_VAL so that reset
  // release never produces a strobe.
  always_ff @(posedge dest_clk or negedge rst_n) begin
    if (!rst_n) begin
      q_hist_q <= RESET_VAL;
    end else begin
      q_hist_q <= q_lvl;
    end
  end

  assign q       = q_lvl;
  assign rise    = q_lvl & ~q_hist_q;
  assign fall    = ~q_lvl & q_hist_q;
  assign changed = |(rise | fall);

endmodule

// File: tb/tb_ff_sync_filt.sv
// Bench for ff_sync_filt: four instances with different STAGES/FILTER/RESET_VAL
// driven by directed scenarios and random words, compared against a
// sliding-window reference model each cycle.
module tb_ff_sync_filt;

  logic       clk;
  logic       rst_n;
  logic [7:0] d_in    [4];
  logic [7:0] q_out   [4];
  logic [7:0] rise_out[4];
  logic [7:0] fall_out[4];
  logic       chg_out [4];

  int checks = 0;
  int passes = 0;
  int nchg_b = 0;
  int nchg_c = 0;

  // Instance 0: STAGES=3 FILTER=0; 1: STAGES=2 FILTER=4;
  // 2: STAGES=2 FILTER=4 RESET_VAL=5A; 3: STAGES=2 FILTER=1.
  ff_sync_filt #(.WIDTH(8), .STAGES(3), .FILTER(0), .RESET_VAL(8'h00)) u_a (
    .dest_clk(clk), .rst_n(rst_n), .d(d_in[0]), .q(q_out[0]),
    .rise(rise_out[0]), .fall(fall_out[0]), .changed(chg_out[0]));
  ff_sync_filt #(.WIDTH(8), .STAGES(2), .FILTER(4), .RESET_VAL(8'h00)) u_b (
    .dest_clk(clk), .rst_n(rst_n), .d(d_in[1]), .q(q_out[1]),
    .rise(rise_out[1]), .fall(fall_out[1]), .changed(chg_out[1]));
  ff_sync_filt #(.WIDTH(8), .STAGES(2), .FILTER(4), .RESET_VAL(8'h5A)) u_c (
    .dest_clk(clk), .rst_n(rst_n), .d(d_in[2]), .q(q_out[2]),
    .rise(rise_out[2]), .fall(fall_out[2]), .changed(chg_out[2]));
  ff_sync_filt #(.WIDTH(8), .STAGES(2), .FILTER(1), .RESET_VAL(8'h00)) u_d (
    .dest_clk(clk), .rst_n(rst_n), .d(d_in[3]), .q(q_out[3]),
    .rise(rise_out[3]), .fall(fall_out[3]), .changed(chg_out[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int stg_of(input int i);
    return (i == 0) ? 3 : 2;
  endfunction

  function automatic int flt_of(input int i);
    case (i)
      0:       return 0;
      1, 2:    return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] rv_of(input int i);
    return (i == 2) ? 8'h5A : 8'h00;
  endfunction

  // Reference model: hist[i][j] is the d word sampled j+1 edges ago.
  // After an edge, unfiltered q is the d sampled STAGES-1 edges back;
  // the filter sees d sampled STAGES edges back and moves q to v once its
  // last FILTER samples all equal v.
  logic [7:0] hist    [4][8];
  logic [7:0] mq      [4];
  logic [7:0] mq_prev [4];

  function automatic logic [7:0] model_next(input int i);
    int st;
    int fl;
    logic [7:0] v;
    st = stg_of(i);
    fl = flt_of(i);
    if (fl == 0) return hist[i][st-2];
    v = hist[i][st-1];
    for (int j = st; j <= st + fl - 2; j++) begin
      if (hist[i][j] != v) return mq[i];
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mq[i]      <= rv_of(i);
        mq_prev[i] <= rv_of(i);
        for (int j = 0; j < 8; j++) hist[i][j] <= rv_of(i);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        mq[i]      <= model_next(i);
        mq_prev[i] <= mq[i];
        hist[i][0] <= d_in[i];
        for (int j = 1; j < 8; j++) hist[i][j] <= hist[i][j-1];
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [7:0] r;
    logic [7:0] f;
    for (int i = 0; i < 4; i++) begin
      r = mq[i] & ~mq_prev[i];
      f = ~mq[i] & mq_prev[i];
      chk($sformatf("q[%0d]", i), q_out[i], mq[i]);
      chk($sformatf("rise[%0d]", i), rise_out[i], r);
      chk($sformatf("fall[%0d]", i), fall_out[i], f);
      chk($sformatf("changed[%0d]", i), {7'b0, chg_out[i]}, {7'b0, |(r | f)});
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    if (chg_out[1]) nchg_b++;
    if (chg_out[2]) nchg_c++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) d_in[i] = rv_of(i);
    repeat (3) @(negedge clk);
    check_all();
    chk("reset_q_c", q_out[2], 8'h5A);
    chk("reset_q_a", q_out[0], 8'h00);
    rst_n = 1'b1;
    run(3);

    // Unfiltered, 3 stages: new word visible after the third edge.
    d_in[0] = 8'hA5;
    run(2);
    chk("a_early_q", q_out[0], 8'h00);
    step();
    chk("a_q", q_out[0], 8'hA5);
    chk("a_rise", rise_out[0], 8'hA5);
    chk("a_fall", fall_out[0], 8'h00);
    chk("a_chg", {7'b0, chg_out[0]}, 8'h01);
    step();
    chk("a_rise_gone", rise_out[0], 8'h00);
    chk("a_chg_gone", {7'b0, chg_out[0]}, 8'h00);
    d_in[0] = 8'hFF;
    run(4);
    d_in[0] = 8'h0F;
    run(3);
    chk("a_fall_f0", fall_out[0], 8'hF0);
    chk("a_rise_00", rise_out[0], 8'h00);
    chk("a_q_0f", q_out[0], 8'h0F);

    // FILTER=4: a 3-cycle glitch is rejected.
    nchg_b = 0;
    d_in[1] = 8'h3C;
    run(3);
    d_in[1] = 8'h00;
    run(10);
    chk("b_glitch_q", q_out[1], 8'h00);
    chk("b_glitch_chg", 8'(nchg_b), 8'd0);
    // Held long enough: q updates on the 6th edge from the first capture.
    d_in[1] = 8'h3C;
    run(5);
    chk("b_early_q", q_out[1], 8'h00);
    step();
    chk("b_q", q_out[1], 8'h3C);
    chk("b_rise", rise_out[1], 8'h3C);
    run(6);
    d_in[1] = 8'h00;
    run(8);
    // Skewed bits arrive as one coherent update.
    nchg_b = 0;
    d_in[1] = 8'h01;
    step();
    d_in[1] = 8'h03;
    run(9);
    chk("b_skew_q", q_out[1], 8'h03);
    chk("b_skew_chg", 8'(nchg_b), 8'd1);

    // Asynchronous reset in the middle of a pending filter count.
    d_in[2] = 8'h00;
    run(8);
    chk("c_q_00", q_out[2], 8'h00);
    d_in[2] = 8'hFF;
    run(3);
    #2 rst_n = 1'b0;
    #1;
    chk("c_async_q", q_out[2], 8'h5A);
    check_all();
    @(negedge clk);
    @(negedge clk);
    d_in[2] = 8'h5A;
    rst_n = 1'b1;
    nchg_c = 0;
    run(12);
    chk("c_quiet_chg", 8'(nchg_c), 8'd0);
    chk("c_quiet_q", q_out[2], 8'h5A);
    d_in[2] = 8'h00;
    run(5);
    chk("c_early_q", q_out[2], 8'h5A);
    step();
    chk("c_q", q_out[2], 8'h00);
    chk("c_fall", fall_out[2], 8'h5A);

    // FILTER=1: bit0 toggles every 2 cycles, 3-edge latency.
    d_in[3] = 8'h00;
    run(4);
    d_in[3] = 8'h01;
    run(2);
    chk("d_early_q", q_out[3], 8'h00);
    step();
    chk("d_q", q_out[3], 8'h01);
    chk("d_rise", rise_out[3], 8'h01);
    for (int k = 0; k < 8; k++) begin
      d_in[3] = d_in[3] ^ 8'h01;
      run(2);
    end

    // Random words with varied hold times, then a random-phase reset.
    repeat (250) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, (i == 1 || i == 2) ? 7 : 3) == 0) begin
          if ($urandom_range(0, 1) == 0) d_in[i] = 8'($urandom);
          else d_in[i] = d_in[i] ^ (8'h01 << $urandom_range(0, 7));
        end
      end
      step();
    end
    #($urandom_range(1, 3)) rst_n = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (250) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, (i == 1 || i == 2) ? 6 : 2) == 0) d_in[i] = 8'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
